// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = $clog2(2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into R
// and subtracts D when it fits, producing one quotient bit.
module divider_step
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem_c,
    output logic             o_qbit_c
);

    logic [WIDTH+1:0] w_trial;

    // R never reaches D, so the trial value always fits back into WIDTH+1 bits
    always_comb begin
        w_trial  = {i_rem, i_bit};
        o_qbit_c = (w_trial >= {2'b00, i_div});
        o_rem_c  = o_qbit_c ? (WIDTH + 1)'(w_trial - {2'b00, i_div})
                            : (WIDTH + 1)'(w_trial);
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module divider_seq
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [2*WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    output logic [2*WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]     o_remainder,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_by_zero
);

    localparam int unsigned QW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(QW);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [QW-1:0]      r_q;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_div;

    logic [WIDTH:0]     w_rem;
    logic               w_qbit;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_q[QW-1]),
        .i_div    (r_div),
        .o_rem_c  (w_rem),
        .o_qbit_c (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_div         <= i_divisor;
                        r_q           <= i_dividend;
                        r_rem         <= '0;
                        r_cnt         <= CNT_W'(QW - 1);
                        o_div_by_zero <= 1'b0;
                        // A zero divisor skips iteration and reports immediately
                        if (i_divisor == '0) begin
                            r_state       <= ST_DONE;
                            o_quotient    <= '1;
                            o_remainder   <= i_dividend[WIDTH-1:0];
                            o_div_by_zero <= 1'b1;
                            o_done        <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            o_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem;
                    r_q   <= {r_q[QW-2:0], w_qbit};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        o_quotient  <= {r_q[QW-2:0], w_qbit};
                        o_remainder <= w_rem[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
